csc_stream_conv: RTL and testbench

// - Parametrised, multi-standard RGB->YCbCr colour-space converter for the JPEG encoder front end.
// - Sits between the pixel source and the block-splitting/DCT stage.
// - Adds valid/ready backpressure, per-pixel mode select and signed saturating arithmetic.
// - Carries SOF/EOL sideband aligned with each pixel.

---
 rtl/csc_pkg.sv | 78 +++++++
 rtl/csc_mac_lane.sv | 64 ++++++
 rtl/csc_stream_conv.sv | 107 ++++++++++
 tb/tb_csc_stream_conv.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared types and standard RGB->YCbCr coefficient tables for the colour-space converter.
// Coefficients and offsets are rounded to 13 fractional bits; offsets are held in whole output LSBs.
package csc_pkg;

    localparam int unsigned CSC_DATA_W = 8;
    localparam int unsigned CSC_COEF_W = 16;
    localparam int unsigned CSC_FRAC_W = 13;

    localparam int CSC_ONE          = 2 ** CSC_FRAC_W;
    localparam int CSC_OFF_C        = 2 ** (CSC_DATA_W - 1);
    localparam int CSC_OFF_Y_STUDIO = 16 * (2 ** (CSC_DATA_W - 8));

    typedef logic signed [CSC_COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        MODE_601_FULL   = 2'd0,
        MODE_709_FULL   = 2'd1,
        MODE_601_STUDIO = 2'd2,
        MODE_USER       = 2'd3
    } csc_mode_e;

    // c[row*3 + col]: rows Y,Cb,Cr; cols R,G,B. off[row] in output LSBs.
    typedef struct packed {
        coef_t [0:8] c;
        coef_t [0:2] off;
    } coef_tbl_t;

    function automatic coef_tbl_t mk_tbl(
        input int yr, input int yg, input int yb,
        input int br, input int bg, input int bb,
        input int rr, input int rg, input int rb,
        input int oy, input int ob, input int orr
    );
        coef_tbl_t t;
        t.c   = {coef_t'(yr), coef_t'(yg), coef_t'(yb),
                 coef_t'(br), coef_t'(bg), coef_t'(bb),
                 coef_t'(rr), coef_t'(rg), coef_t'(rb)};
        t.off = {coef_t'(oy), coef_t'(ob), coef_t'(orr)};
        return t;
    endfunction

    localparam coef_tbl_t BT601_FULL = mk_tbl(
         2449,  4809,   934,
        -1382, -2714,  4096,
         4096, -3430,  -666,
        0, CSC_OFF_C, CSC_OFF_C);

    localparam coef_tbl_t BT709_FULL = mk_tbl(
         1742,  5859,   591,
         -939, -3157,  4096,
         4096, -3720,  -376,
        0, CSC_OFF_C, CSC_OFF_C);

    localparam coef_tbl_t BT601_STUDIO = mk_tbl(
         2104,  4130,   802,
        -1214, -2384,  3598,
         3598, -3013,  -585,
        CSC_OFF_Y_STUDIO, CSC_OFF_C, CSC_OFF_C);

    // Identity routing R->Cr, G->Cb, B->Y so the MAC lanes pass {R,G,B} through unchanged.
    localparam coef_tbl_t BYPASS_TBL = mk_tbl(
        0,       0,       CSC_ONE,
        0,       CSC_ONE, 0,
        CSC_ONE, 0,       0,
        0, 0, 0);

    function automatic coef_tbl_t std_table(input csc_mode_e m);
        coef_tbl_t t;
        case (m)
            MODE_601_FULL:   t = BT601_FULL;
            MODE_709_FULL:   t = BT709_FULL;
            MODE_601_STUDIO: t = BT601_STUDIO;
            default:         t = BYPASS_TBL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/csc_mac_lane.sv
// One output channel of the converter: S1 products, S2 sum+offset+round, S3 shift/saturate/output.
// Every stage register advances only when adv is high.
module csc_mac_lane #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC_W = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv,
    input  logic [3*DATA_W-1:0]      pix,
    input  logic signed [COEF_W-1:0] c_r,
    input  logic signed [COEF_W-1:0] c_g,
    input  logic signed [COEF_W-1:0] c_b,
    input  logic signed [COEF_W-1:0] off,
    output logic [DATA_W-1:0]        res
);

    localparam int unsigned PROD_W = COEF_W + DATA_W + 1;
    localparam int unsigned ACC_W  = COEF_W + DATA_W + 3;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** DATA_W - 1);

    logic signed [PROD_W-1:0] prod_r, prod_g, prod_b;
    logic signed [ACC_W-1:0]  off_q, acc_q, shr;
    logic [DATA_W-1:0]        sat;

    // S1: components are zero-extended before the signed multiply.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_r <= PROD_W'(c_r) * PROD_W'($signed({1'b0, pix[3*DATA_W-1 -: DATA_W]}));
            prod_g <= PROD_W'(c_g) * PROD_W'($signed({1'b0, pix[2*DATA_W-1 -: DATA_W]}));
            prod_b <= PROD_W'(c_b) * PROD_W'($signed({1'b0, pix[DATA_W-1:0]}));
            off_q  <= ACC_W'(off) <<< FRAC_W;
        end
    end

    // S2
    always_ff @(posedge clk) begin
        if (adv) begin
            acc_q <= ACC_W'(prod_r) + ACC_W'(prod_g) + ACC_W'(prod_b) + off_q + RND;
        end
    end

    always_comb begin
        shr = acc_q >>> FRAC_W;
        sat = shr[DATA_W-1:0];
        if (shr[ACC_W-1]) begin
            sat = '0;
        end else if (shr > SAT_MAX) begin
            sat = '1;
        end
    end

    // S3
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
        end else if (adv) begin
            res <= sat;
        end
    end

endmodule

// File: rtl/csc_stream_conv.sv
// RGB->YCbCr stream converter with valid/ready backpressure and SOF/EOL sideband, 3-cycle latency.
// Optional CSC_PROG_COEF_EN adds a writable coefficient table selected by mode 3 (otherwise bypass).
module csc_stream_conv
    import csc_pkg::*;
#(
    parameter int unsigned DATA_W = CSC_DATA_W,
    parameter int unsigned COEF_W = CSC_COEF_W,
    parameter int unsigned FRAC_W = CSC_FRAC_W
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CSC_PROG_COEF_EN
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [COEF_W-1:0]   cfg_wdata,
`endif
    input  logic [1:0]          mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [3*DATA_W-1:0] s_data,
    input  logic                s_sof,
    input  logic                s_eol,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [3*DATA_W-1:0] m_data,
    output logic                m_sof,
    output logic                m_eol
);

    logic      adv;
    logic      vld1, vld2, sof1, sof2, eol1, eol2;
    coef_tbl_t tbl;

    assign adv     = m_ready | ~m_valid;
    assign s_ready = adv;

`ifdef CSC_PROG_COEF_EN
    coef_tbl_t user_tbl;

    // The table register updates at the edge, so a same-cycle accept still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            user_tbl <= BT601_FULL;
        end else if (cfg_we) begin
            if (cfg_addr <= 4'd8) begin
                user_tbl.c[cfg_addr] <= coef_t'(cfg_wdata);
            end else if (cfg_addr <= 4'd11) begin
                user_tbl.off[2'(cfg_addr - 4'd9)] <= coef_t'(cfg_wdata);
            end
        end
    end
`endif

    always_comb begin
        tbl = std_table(csc_mode_e'(mode));
`ifdef CSC_PROG_COEF_EN
        if (csc_mode_e'(mode) == MODE_USER) begin
            tbl = user_tbl;
        end
`endif
    end

    // Lane 0 = Y (LSBs), lane 1 = Cb, lane 2 = Cr (MSBs).
    for (genvar r = 0; r < 3; r++) begin : g_lane
        csc_mac_lane #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .adv (adv),
            .pix (s_data),
            .c_r (COEF_W'(tbl.c[3*r])),
            .c_g (COEF_W'(tbl.c[3*r+1])),
            .c_b (COEF_W'(tbl.c[3*r+2])),
            .off (COEF_W'(tbl.off[r])),
            .res (m_data[r*DATA_W +: DATA_W])
        );
    end

    // Valid and sideband pipe, lock-stepped with the lane stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1    <= 1'b0;
            vld2    <= 1'b0;
            m_valid <= 1'b0;
            sof1    <= 1'b0;
            sof2    <= 1'b0;
            m_sof   <= 1'b0;
            eol1    <= 1'b0;
            eol2    <= 1'b0;
            m_eol   <= 1'b0;
        end else if (adv) begin
            vld1    <= s_valid;
            vld2    <= vld1;
            m_valid <= vld2;
            sof1    <= s_valid & s_sof;
            sof2    <= sof1;
            m_sof   <= sof2;
            eol1    <= s_valid & s_eol;
            eol2    <= eol1;
            m_eol   <= eol2;
        end
    end

endmodule

// File: tb/tb_csc_stream_conv.sv
// Directed bench for csc_stream_conv: known colours, latency, bubbles, reset flush and backpressure.
module tb_csc_stream_conv;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, s_sof, s_eol, m_valid, m_ready, m_sof, m_eol;
    logic [1:0]  mode;
    logic [23:0] s_data, m_data;
`ifdef CSC_PROG_COEF_EN
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
`endif

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic mon_en = 1'b1;
    logic held = 1'b0;
    logic [25:0] held_v;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    csc_stream_conv dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CSC_PROG_COEF_EN
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
`endif
        .mode      (mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Integer reference: {Cr,Cb,Y,sof,eol}
    function automatic logic [25:0] model(input logic [1:0] md, input logic [23:0] rgb,
                                          input logic sof, input logic eol);
        int k[12];
        int x[3];
        int acc;
        int res;
        logic byp;
        logic [23:0] o;
        x[0] = int'(rgb[23:16]);
        x[1] = int'(rgb[15:8]);
        x[2] = int'(rgb[7:0]);
        o    = rgb;
        byp  = 1'b0;
        k    = '{2449, 4809, 934, -1382, -2714, 4096, 4096, -3430, -666, 0, 128, 128};
        case (md)
            2'd1: k = '{1742, 5859, 591, -939, -3157, 4096, 4096, -3720, -376, 0, 128, 128};
            2'd2: k = '{2104, 4130, 802, -1214, -2384, 3598, 3598, -3013, -585, 16, 128, 128};
`ifndef CSC_PROG_COEF_EN
            2'd3: byp = 1'b1;
`endif
            default: ;
        endcase
        if (!byp) begin
            for (int ch = 0; ch < 3; ch++) begin
                acc = k[3*ch]*x[0] + k[3*ch+1]*x[1] + k[3*ch+2]*x[2] + k[9+ch]*8192;
                res = (acc + 4096) >>> 13;
                if (res < 0) res = 0;
                else if (res > 255) res = 255;
                o[8*ch +: 8] = 8'(res);
            end
        end
        return {o, sof, eol};
    endfunction

    // Scoreboard: compare every handshake, and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) check("stall_hold", {5'd0, m_valid, m_data, m_sof, m_eol}, {5'd0, 1'b1, held_v});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("stream_out", {6'd0, m_data, m_sof, m_eol}, {6'd0, exp_q.pop_front()});
                    n_out++;
                end
            end
            held   = m_valid && !m_ready;
            held_v = {m_data, m_sof, m_eol};
            if (s_valid && s_ready) exp_q.push_back(model(mode, s_data, s_sof, s_eol));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single pixel into an empty pipe; check latency and value.
    task automatic run_vec(input string tag, input logic [1:0] md, input logic [23:0] rgb,
                           input logic [23:0] exp);
        int n = 0;
        mode = md; s_data = rgb; s_sof = 1'b0; s_eol = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        while (!m_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check(tag, {8'd0, m_data}, {8'd0, exp});
        step();
    endtask

    task automatic load_pix(input int i);
        mode    = 2'($urandom_range(0, 3));
        s_data  = 24'($urandom);
        s_sof   = (i == 0);
        s_eol   = (i % 4 == 3);
        s_valid = 1'b1;
    endtask

    initial begin
        int i;
        int cyc;
        int n_before;
        logic acc;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        mode = 2'd0; s_data = '0;
`ifdef CSC_PROG_COEF_EN
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
`endif
        repeat (2) step();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {8'd0, m_data}, 32'd0);
        check("rst_sideband", {30'd0, m_sof, m_eol}, 32'd0);
        rst = 1'b0;
        step();
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);

        run_vec("m0_white", 2'd0, {8'd255, 8'd255, 8'd255}, {8'd128, 8'd128, 8'd255});
        run_vec("m0_black", 2'd0, {8'd0, 8'd0, 8'd0}, {8'd128, 8'd128, 8'd0});
        run_vec("m0_red",   2'd0, {8'd255, 8'd0, 8'd0}, {8'd255, 8'd85, 8'd76});
        run_vec("m0_blue",  2'd0, {8'd0, 8'd0, 8'd255}, {8'd107, 8'd255, 8'd29});
        run_vec("m1_white", 2'd1, {8'd255, 8'd255, 8'd255}, {8'd128, 8'd128, 8'd255});
        run_vec("m2_black", 2'd2, {8'd0, 8'd0, 8'd0}, {8'd128, 8'd128, 8'd16});
        run_vec("m2_white", 2'd2, {8'd255, 8'd255, 8'd255}, {8'd128, 8'd128, 8'd235});
`ifdef CSC_PROG_COEF_EN
        run_vec("m3_user_rst", 2'd3, {8'd12, 8'd34, 8'd56}, {8'd115, 8'd143, 8'd30});
`else
        run_vec("m3_bypass", 2'd3, {8'd12, 8'd34, 8'd56}, {8'd12, 8'd34, 8'd56});
`endif

        // Alternating s_valid gives alternating m_valid three cycles later.
        for (int c = 0; c < 12; c++) begin
            mode    = 2'd3;
            s_data  = {8'(c * 10), 8'(c + 1), 8'(255 - c)};
            s_valid = (c < 8) && (c % 2 == 0);
            if (c >= 3) check("alt_valid", {31'd0, m_valid}, {31'd0, 1'((c - 3) < 8 && (c - 3) % 2 == 0)});
            step();
        end
        s_valid = 1'b0;

        // Reset with three pixels in flight.
        mode = 2'd0;
        for (int c = 0; c < 3; c++) begin
            s_data = {8'(40 * c), 8'd90, 8'd200}; s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0; rst = 1'b1;
        step();
        check("rst_flush_valid", {31'd0, m_valid}, 32'd0);
        rst = 1'b0; m_ready = 1'b1;
        step();
        check("rst_flush_ready", {31'd0, s_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            check("rst_no_stale", {31'd0, m_valid}, 32'd0);
            step();
        end

        // Backpressure stream of 16 pixels with random m_ready.
        n_before = n_out;
        i = 0; cyc = 0;
        load_pix(0);
        while (i < 16 && cyc < 400) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            step();
            cyc++;
            m_ready = 1'($urandom_range(0, 1));
            if (acc) begin
                i++;
                if (i < 16) load_pix(i);
                else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        check("stream_sent", 32'(i), 32'd16);
        m_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        repeat (4) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("stream_count", 32'(n_out - n_before), 32'd16);

`ifdef CSC_PROG_COEF_EN
        // User table: Y = R exactly, chroma rows zeroed around their offsets.
        mon_en = 1'b0;
        for (int a = 0; a < 12; a++) begin
            cfg_we = 1'b1; cfg_addr = 4'(a);
            cfg_wdata = (a == 0) ? 16'd8192 : ((a == 10 || a == 11) ? 16'd128 : 16'd0);
            step();
        end
        cfg_we = 1'b0;
        run_vec("prog_y", 2'd3, {8'd200, 8'd7, 8'd9}, {8'd128, 8'd128, 8'd200});
        mode = 2'd3; s_data = {8'd100, 8'd0, 8'd0}; s_valid = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'd4096;
        step();
        cfg_we = 1'b0;
        step();
        s_valid = 1'b0;
        step();
        check("prog_same_cycle", {8'd0, m_data}, {8'd0, 8'd128, 8'd128, 8'd100});
        step();
        check("prog_next_pixel", {8'd0, m_data}, {8'd0, 8'd128, 8'd128, 8'd50});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
